// File: rtl/aspen_neuron_pkg.sv
// Shared types and constants for the integrate-and-fire neuron stages.
package aspen_neuron_pkg;

  typedef enum logic {
    ACCUM  = 1'b0,
    UPDATE = 1'b1
  } state_t;

  localparam int RESET_ZERO = 0;
  localparam int RESET_SUB  = 1;

endpackage

// File: rtl/lif_accum_5x2_sat_add.sv
// Unsigned saturating adder: clamps to all-ones on carry out and flags it.
module sat_add_u #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         sat
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign sat  = full[W];
  assign sum  = full[W] ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/lif_accum_5x2.sv
// Integrate-and-fire stage: accumulates 4-bit partial sums into a saturating
// membrane potential and resolves fire/leak once per timestep.
module lif_accum_5x2
  import aspen_neuron_pkg::*;
#(
  parameter int ACC_W      = 12,
  parameter int THRESH     = 64,
  parameter int LEAK_SHIFT = 3,
  parameter int RESET_MODE = RESET_SUB,
  parameter int NUM_CHUNKS = 8,
  parameter int TSTEP_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         psum,
  input  logic               psum_valid,
  input  logic               psum_last,
  output logic               psum_ready,
  output logic               spike_valid,
  output logic               spike,
  output logic [ACC_W-1:0]   vmem,
  output logic               sat_flag,
  output logic [TSTEP_W-1:0] tstep
);

  localparam int               CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [ACC_W-1:0] THR   = ACC_W'(THRESH);

  function automatic logic [ACC_W-1:0] leak(input logic [ACC_W-1:0] v);
    return v - (v >> LEAK_SHIFT);
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] chunk_cnt;
  logic             hs, close_ts, add_sat, fire;
  logic [ACC_W-1:0] add_sum, vmem_upd;

  assign psum_ready = (state == ACCUM) && !rst;
  assign hs         = psum_valid && psum_ready;
  assign close_ts   = psum_last || (chunk_cnt == CNT_W'(NUM_CHUNKS - 1));

  sat_add_u #(.W(ACC_W)) u_sat_add (
    .a   (vmem),
    .b   (ACC_W'(psum)),
    .sum (add_sum),
    .sat (add_sat)
  );

  assign fire     = (vmem >= THR);
  assign vmem_upd = fire ? ((RESET_MODE == RESET_SUB) ? (vmem - THR) : '0) : leak(vmem);

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (hs && close_ts) state_nxt = UPDATE;
      UPDATE:  state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACCUM;
      vmem        <= '0;
      chunk_cnt   <= '0;
      spike_valid <= 1'b0;
      spike       <= 1'b0;
      sat_flag    <= 1'b0;
      tstep       <= '0;
    end else begin
      state       <= state_nxt;
      spike_valid <= 1'b0;
      if (hs) begin
        vmem      <= add_sum;
        // First chunk of a timestep restarts the sticky saturation flag.
        sat_flag  <= (chunk_cnt == '0) ? add_sat : (sat_flag | add_sat);
        chunk_cnt <= close_ts ? '0 : chunk_cnt + CNT_W'(1);
      end
      if (state == UPDATE) begin
        vmem        <= vmem_upd;
        spike       <= fire;
        spike_valid <= 1'b1;
        tstep       <= tstep + TSTEP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lif_accum_5x2.sv
// Directed bench for lif_accum_5x2 across three parameterisations.
module tb_lif_accum_5x2;

  logic        clk, rst;
  logic [3:0]  psum;
  logic        psum_last;
  logic        valid_a, valid_b, valid_c;
  logic        ready_a, ready_b, ready_c;
  logic        sv_a, sv_b, sv_c;
  logic        spike_a, spike_b, spike_c;
  logic [11:0] vmem_a, vmem_c;
  logic [5:0]  vmem_b;
  logic        sat_a, sat_b, sat_c;
  logic [7:0]  tstep_a, tstep_b, tstep_c;

  int checks = 0;
  int errors = 0;

  lif_accum_5x2 dut_a (
    .clk(clk), .rst(rst), .psum(psum), .psum_valid(valid_a), .psum_last(psum_last),
    .psum_ready(ready_a), .spike_valid(sv_a), .spike(spike_a), .vmem(vmem_a),
    .sat_flag(sat_a), .tstep(tstep_a)
  );

  lif_accum_5x2 #(.ACC_W(6), .THRESH(60)) dut_b (
    .clk(clk), .rst(rst), .psum(psum), .psum_valid(valid_b), .psum_last(psum_last),
    .psum_ready(ready_b), .spike_valid(sv_b), .spike(spike_b), .vmem(vmem_b),
    .sat_flag(sat_b), .tstep(tstep_b)
  );

  lif_accum_5x2 #(.NUM_CHUNKS(4), .RESET_MODE(0)) dut_c (
    .clk(clk), .rst(rst), .psum(psum), .psum_valid(valid_c), .psum_last(psum_last),
    .psum_ready(ready_c), .spike_valid(sv_c), .spike(spike_c), .vmem(vmem_c),
    .sat_flag(sat_c), .tstep(tstep_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  typedef struct {
    logic        ready, sv, spike, sat;
    logic [31:0] vmem, tstep;
  } obs_t;

  typedef struct {
    int          n;
    logic [31:0] p;
    logic        last;
    int          exp_pre;
    logic        exp_spike;
    int          exp_vmem;
    int          exp_tstep;
  } vec_t;

  function automatic obs_t obs(input int sel);
    obs_t o;
    case (sel)
      0: o = '{ready_a, sv_a, spike_a, sat_a, 32'(vmem_a), 32'(tstep_a)};
      1: o = '{ready_b, sv_b, spike_b, sat_b, 32'(vmem_b), 32'(tstep_b)};
      default: o = '{ready_c, sv_c, spike_c, sat_c, 32'(vmem_c), 32'(tstep_c)};
    endcase
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1; returns how many cycles ready was low.
  task automatic send(input int sel, input logic [3:0] p, input logic l, output int waited);
    bit got = 0;
    waited = 0;
    psum = p;
    psum_last = l;
    valid_a = (sel == 0);
    valid_b = (sel == 1);
    valid_c = (sel == 2);
    while (!got && waited < 10) begin
      @(negedge clk);
      if (obs(sel).ready) got = 1;
      else waited++;
      @(posedge clk);
      #1;
    end
    check("accept", 32'(got), 32'd1);
    valid_a = 0; valid_b = 0; valid_c = 0;
    psum_last = 0;
  endtask

  // Call right after the closing chunk's handshake.
  task automatic expect_update(input int sel, input int pre, input logic sp, input int vm,
                               input int ts, input logic sat);
    obs_t o;
    @(negedge clk);
    o = obs(sel);
    check("update_ready", 32'(o.ready), 32'd0);
    check("update_vmem_pre", o.vmem, 32'(pre));
    check("update_sv_low", 32'(o.sv), 32'd0);
    @(negedge clk);
    o = obs(sel);
    check("spike_valid", 32'(o.sv), 32'd1);
    check("spike", 32'(o.spike), 32'(sp));
    check("vmem_after", o.vmem, 32'(vm));
    check("tstep", o.tstep, 32'(ts));
    check("sat_flag", 32'(o.sat), 32'(sat));
    check("ready_after", 32'(o.ready), 32'd1);
    @(negedge clk);
    o = obs(sel);
    check("spike_valid_pulse", 32'(o.sv), 32'd0);
    check("spike_hold", 32'(o.spike), 32'(sp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl[6];
    obs_t o;
    int w;

    tbl[0] = '{4, 32'h0000_AFFF, 1'b1, 55,  1'b0, 49, 1};
    tbl[1] = '{2, 32'h0000_005F, 1'b1, 69,  1'b1, 5,  2};
    tbl[2] = '{3, 32'h0000_0000, 1'b1, 5,   1'b0, 5,  3};
    tbl[3] = '{8, 32'hFFFF_FFFF, 1'b0, 125, 1'b1, 61, 4};
    tbl[4] = '{8, 32'h0000_0000, 1'b1, 61,  1'b0, 54, 5};
    tbl[5] = '{1, 32'h0000_0003, 1'b1, 57,  1'b0, 50, 6};

    rst = 1; psum = 0; psum_last = 0; valid_a = 0; valid_b = 0; valid_c = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    o = obs(0);
    check("rst_vmem", o.vmem, 32'd0);
    check("rst_sv", 32'(o.sv), 32'd0);
    check("rst_spike", 32'(o.spike), 32'd0);
    check("rst_sat", 32'(o.sat), 32'd0);
    check("rst_tstep", o.tstep, 32'd0);
    check("rst_ready_low", 32'(o.ready), 32'd0);
    rst = 0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) check("ready_after_rst", 32'(obs(s).ready), 32'd1);
    @(posedge clk);
    #1;

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < tbl[r].n; i++) begin
        send(0, tbl[r].p[4*i +: 4], tbl[r].last && (i == tbl[r].n - 1), w);
        check("back_to_back", 32'(w), 32'd0);
      end
      expect_update(0, tbl[r].exp_pre, tbl[r].exp_spike, tbl[r].exp_vmem, tbl[r].exp_tstep, 1'b0);
    end

    // valid held through UPDATE: nothing taken in the bubble, taken one cycle later
    send(0, 4'd14, 1'b1, w);
    psum = 4'd2; psum_last = 0; valid_a = 1;
    @(negedge clk);
    check("hold_update_ready", 32'(ready_a), 32'd0);
    @(negedge clk);
    check("hold_sv", 32'(sv_a), 32'd1);
    check("hold_spike", 32'(spike_a), 32'd1);
    check("hold_vmem_no_add", 32'(vmem_a), 32'd0);
    check("hold_tstep", 32'(tstep_a), 32'd7);
    @(posedge clk);
    #1;
    valid_a = 0;
    @(negedge clk);
    check("hold_vmem_added", 32'(vmem_a), 32'd2);
    check("hold_sv_low", 32'(sv_a), 32'd0);
    @(posedge clk);
    #1;
    send(0, 4'd0, 1'b1, w);
    expect_update(0, 2, 1'b0, 2, 8, 1'b0);

    // reset during UPDATE discards the timestep
    send(0, 4'd3, 1'b1, w);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check("abort_vmem", 32'(vmem_a), 32'd0);
    check("abort_tstep", 32'(tstep_a), 32'd0);
    check("abort_sv", 32'(sv_a), 32'd0);
    check("abort_ready", 32'(ready_a), 32'd1);
    @(negedge clk);
    check("abort_no_late_spike", 32'(sv_a), 32'd0);
    @(posedge clk);
    #1;

    // saturation on a 6-bit membrane
    for (int i = 0; i < 5; i++) send(1, 4'd15, i == 4, w);
    expect_update(1, 63, 1'b1, 3, 1, 1'b1);
    send(1, 4'd1, 1'b0, w);
    @(negedge clk);
    check("sat_cleared", 32'(sat_b), 32'd0);
    check("sat_next_vmem", 32'(vmem_b), 32'd4);
    @(posedge clk);
    #1;
    send(1, 4'd0, 1'b1, w);
    expect_update(1, 4, 1'b0, 4, 2, 1'b0);

    // implicit close at NUM_CHUNKS=4, reset-to-zero fire
    for (int i = 0; i < 4; i++) send(2, 4'd1, 1'b0, w);
    expect_update(2, 4, 1'b0, 4, 1, 1'b0);
    for (int i = 0; i < 4; i++) send(2, 4'd15, 1'b0, w);
    expect_update(2, 64, 1'b1, 0, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
